// File: rtl/cpu_cu_pkg.sv
// Shared definitions for the cpu_cu control unit: opcodes, FSM states,
// instruction classes, flag and control-bundle types.
package cpu_cu_pkg;

  localparam logic [3:0] OP_NOP    = 4'h0;
  localparam logic [3:0] OP_ALU_LO = 4'h1;
  localparam logic [3:0] OP_ALU_HI = 4'h2;
  localparam logic [3:0] OP_LD     = 4'h3;
  localparam logic [3:0] OP_ST     = 4'h4;
  localparam logic [3:0] OP_BR     = 4'h5;
  localparam logic [3:0] OP_BEQ    = 4'h6;
  localparam logic [3:0] OP_BNE    = 4'h7;
  localparam logic [3:0] OP_BMI    = 4'h8;
  localparam logic [3:0] OP_BCS    = 4'h9;
  localparam logic [3:0] OP_JR     = 4'hA;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [3:0] ALU_PASS_R = 4'h0;
  localparam logic [3:0] ALU_PASS_S = 4'h1;

  typedef enum logic [2:0] {
    RST,
    FETCH,
    DECODE,
    EXEC,
    HALT
  } state_e;

  typedef enum logic [2:0] {
    CLS_NOP,
    CLS_ALU,
    CLS_LD,
    CLS_ST,
    CLS_BRANCH,
    CLS_JR,
    CLS_HALT,
    CLS_ILLEGAL
  } instr_cls_e;

  typedef enum logic [2:0] {
    COND_ALWAYS,
    COND_EQ,
    COND_NE,
    COND_MI,
    COND_CS
  } cond_e;

  typedef struct packed {
    logic c;
    logic n;
    logic z;
  } flags_t;

  typedef struct packed {
    logic       w_en;
    logic       s_sel;
    logic       pc_ld;
    logic       pc_inc;
    logic       ir_ld;
    logic       adr_sel;
    logic       pc_sel;
    logic       mem_rd;
    logic       mem_we;
    logic [2:0] w_adr;
    logic [2:0] r_adr;
    logic [2:0] s_adr;
    logic [3:0] alu_op;
  } ctl_t;

  function automatic logic cond_met(input cond_e cond, input flags_t f);
    logic met;
    case (cond)
      COND_EQ: met = f.z;
      COND_NE: met = !f.z;
      COND_MI: met = f.n;
      COND_CS: met = f.c;
      default: met = 1'b1;
    endcase
    return met;
  endfunction

endpackage

// File: rtl/cpu_cu_if.sv
// Control-unit <-> execution-unit/memory bus. The master side is the
// control unit; the slave side is the execution unit plus memory.
interface cpu_cu_if;
  logic [15:0] ir_out;
  logic        C;
  logic        N;
  logic        Z;
  logic        mem_rdy;

  logic        w_en;
  logic        s_sel;
  logic        pc_ld;
  logic        pc_inc;
  logic        ir_ld;
  logic        adr_sel;
  logic        pc_sel;
  logic [2:0]  W_Adr;
  logic [2:0]  R_Adr;
  logic [2:0]  S_Adr;
  logic [3:0]  ALU_OP;
  logic        mem_rd;
  logic        mem_we;
  logic        halted;
  logic        illegal;

  modport master (
    input  ir_out, C, N, Z, mem_rdy,
    output w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, pc_sel,
    output W_Adr, R_Adr, S_Adr, ALU_OP, mem_rd, mem_we, halted, illegal
  );

  modport slave (
    output ir_out, C, N, Z, mem_rdy,
    input  w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, pc_sel,
    input  W_Adr, R_Adr, S_Adr, ALU_OP, mem_rd, mem_we, halted, illegal
  );
endinterface

// File: rtl/cpu_cu_decode.sv
// Combinational instruction decoder: splits the IR into register fields,
// classifies the opcode and selects the branch condition.
module cpu_cu_decode
  import cpu_cu_pkg::*;
(
  input  logic [15:0] ir,
  output instr_cls_e  cls,
  output cond_e       cond,
  output logic [2:0]  w_adr,
  output logic [2:0]  r_adr,
  output logic [2:0]  s_adr,
  output logic [3:0]  alu_op,
  output logic        illegal
);

  logic [3:0] op;

  assign op     = ir[15:12];
  assign w_adr  = ir[11:9];
  assign r_adr  = ir[8:6];
  assign s_adr  = ir[5:3];
  // Opcode 2 selects the upper half of the ALU function space.
  assign alu_op = {op == OP_ALU_HI, ir[2:0]};

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case leaves it unassigned (which would infer a latch).
  always_comb begin
    cls  = CLS_ILLEGAL;
    cond = COND_ALWAYS;
    case (op)
      OP_NOP:               cls = CLS_NOP;
      OP_ALU_LO, OP_ALU_HI: cls = CLS_ALU;
      OP_LD:                cls = CLS_LD;
      OP_ST:                cls = CLS_ST;
      OP_BR:                cls = CLS_BRANCH;
      OP_BEQ: begin
        cls  = CLS_BRANCH;
        cond = COND_EQ;
      end
      OP_BNE: begin
        cls  = CLS_BRANCH;
        cond = COND_NE;
      end
      OP_BMI: begin
        cls  = CLS_BRANCH;
        cond = COND_MI;
      end
      OP_BCS: begin
        cls  = CLS_BRANCH;
        cond = COND_CS;
      end
      OP_JR:                cls = CLS_JR;
      OP_HALT:              cls = CLS_HALT;
      default:              cls = CLS_ILLEGAL;
    endcase
  end

  assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/cpu_cu.sv
// Control unit FSM for the 16-bit RISC core: sequences fetch/decode/execute,
// keeps the branch flag register and drives every execution-unit control.
module cpu_cu
  import cpu_cu_pkg::*;
#(
  parameter int unsigned RST_PC_HOLD = 0
)
(
  input logic      clk,
  input logic      reset,
  cpu_cu_if.master bus
);

  localparam logic [1:0] HOLD_LAST = RST_PC_HOLD[1:0];

  state_e     state;
  flags_t     flags;
  logic [1:0] hold_cnt;
  logic       halted_q;
  logic       illegal_q;
  ctl_t       ctl;

  instr_cls_e cls;
  cond_e      cond;
  logic [2:0] dec_w;
  logic [2:0] dec_r;
  logic [2:0] dec_s;
  logic [3:0] dec_alu_op;
  logic       dec_illegal;
  logic       cond_ok;
  logic       mem_op;

  cpu_cu_decode u_decode (
    .ir      (bus.ir_out),
    .cls     (cls),
    .cond    (cond),
    .w_adr   (dec_w),
    .r_adr   (dec_r),
    .s_adr   (dec_s),
    .alu_op  (dec_alu_op),
    .illegal (dec_illegal)
  );

  assign cond_ok = cond_met(cond, flags);
  assign mem_op  = (cls == CLS_LD) || (cls == CLS_ST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= RST;
      flags     <= '0;
      hold_cnt  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state)
        RST: begin
          if (hold_cnt == HOLD_LAST) state <= FETCH;
          else                       hold_cnt <= hold_cnt + 2'd1;
        end
        FETCH: begin
          if (bus.mem_rdy) state <= DECODE;
        end
        DECODE: begin
          if (dec_illegal) begin
            state     <= HALT;
            halted_q  <= 1'b1;
            illegal_q <= 1'b1;
          end else if (cls == CLS_HALT) begin
            state    <= HALT;
            halted_q <= 1'b1;
          end else begin
            state <= EXEC;
          end
        end
        EXEC: begin
          // Only ALU results update the flags that later branches test.
          if (cls == CLS_ALU) flags <= '{c: bus.C, n: bus.N, z: bus.Z};
          if (!mem_op || bus.mem_rdy) state <= FETCH;
        end
        HALT:    state <= HALT;
        default: state <= RST;
      endcase
    end
  end

  // Controls are decoded from the current state so an asynchronous reset
  // removes every strobe immediately, including mid-transfer.
  always_comb begin
    ctl = '0;
    case (state)
      FETCH: begin
        ctl.mem_rd = 1'b1;
        ctl.ir_ld  = bus.mem_rdy;
        ctl.pc_inc = bus.mem_rdy;
      end
      EXEC: begin
        case (cls)
          CLS_ALU: begin
            ctl.w_en   = 1'b1;
            ctl.w_adr  = dec_w;
            ctl.r_adr  = dec_r;
            ctl.s_adr  = dec_s;
            ctl.alu_op = dec_alu_op;
          end
          CLS_LD: begin
            ctl.adr_sel = 1'b1;
            ctl.mem_rd  = 1'b1;
            ctl.s_sel   = 1'b1;
            ctl.r_adr   = dec_r;
            ctl.w_adr   = dec_w;
            ctl.alu_op  = ALU_PASS_S;
            ctl.w_en    = bus.mem_rdy;
          end
          CLS_ST: begin
            ctl.adr_sel = 1'b1;
            ctl.mem_we  = 1'b1;
            ctl.r_adr   = dec_r;
            ctl.s_adr   = dec_s;
            ctl.alu_op  = ALU_PASS_S;
          end
          CLS_BRANCH: begin
            ctl.pc_sel = 1'b0;
            ctl.pc_ld  = cond_ok;
          end
          CLS_JR: begin
            ctl.r_adr  = dec_r;
            ctl.alu_op = ALU_PASS_R;
            ctl.pc_sel = 1'b1;
            ctl.pc_ld  = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.w_en    = ctl.w_en;
  assign bus.s_sel   = ctl.s_sel;
  assign bus.pc_ld   = ctl.pc_ld;
  assign bus.pc_inc  = ctl.pc_inc;
  assign bus.ir_ld   = ctl.ir_ld;
  assign bus.adr_sel = ctl.adr_sel;
  assign bus.pc_sel  = ctl.pc_sel;
  assign bus.mem_rd  = ctl.mem_rd;
  assign bus.mem_we  = ctl.mem_we;
  assign bus.W_Adr   = ctl.w_adr;
  assign bus.R_Adr   = ctl.r_adr;
  assign bus.S_Adr   = ctl.s_adr;
  assign bus.ALU_OP  = ctl.alu_op;
  assign bus.halted  = halted_q;
  assign bus.illegal = illegal_q;

endmodule

// File: tb/tb_cpu_cu.sv
// Self-checking bench for cpu_cu: the bench plays execution unit and memory,
// keeps an architectural PC/flag model and checks every cycle's controls.
module tb_cpu_cu;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_cu_if bus ();

  cpu_cu #(.RST_PC_HOLD(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Observation vector layout.
  localparam int B_HALTED  = 23;
  localparam int B_ILLEGAL = 22;
  localparam int B_WEN     = 21;
  localparam int B_SSEL    = 20;
  localparam int B_PCLD    = 19;
  localparam int B_PCINC   = 18;
  localparam int B_IRLD    = 17;
  localparam int B_ADRSEL  = 16;
  localparam int B_PCSEL   = 15;
  localparam int B_MEMRD   = 14;
  localparam int B_MEMWE   = 13;
  // Strobes that must be exactly as expected in every cycle.
  localparam logic [23:0] M_STROBES = 24'b1110_1110_0110_0000_0000_0000;
  localparam logic [23:0] M_ALLCTL  = 24'b1111_1111_1110_0000_0000_0000;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] regs [8];
  logic [15:0] eu_pc;
  logic        m_c, m_n, m_z;

  function automatic logic [23:0] observe();
    return {bus.halted, bus.illegal, bus.w_en, bus.s_sel, bus.pc_ld, bus.pc_inc,
            bus.ir_ld, bus.adr_sel, bus.pc_sel, bus.mem_rd, bus.mem_we,
            bus.W_Adr, bus.R_Adr, bus.S_Adr, bus.ALU_OP};
  endfunction

  task automatic set_flags(input logic [2:0] cnz);
    {bus.C, bus.N, bus.Z} = cnz;
  endtask

  // Advance one clock and apply the strobes seen this cycle to the EU model.
  task automatic clock_eu(input logic [23:0] ob, input logic [15:0] ir);
    @(posedge clk);
    #1;
    if (ob[B_PCINC]) eu_pc = eu_pc + 16'd1;
    if (ob[B_PCLD])
      eu_pc = ob[B_PCSEL] ? regs[ob[9:7]]
                          : eu_pc + {{8{bus.ir_out[7]}}, bus.ir_out[7:0]};
    if (ob[B_IRLD]) bus.ir_out = ir;
  endtask

  // Leaves the DUT in its first FETCH cycle, just after a rising edge.
  task automatic do_reset();
    reset       = 1'b0;
    bus.mem_rdy = 1'b0;
    bus.ir_out  = '0;
    set_flags(3'b000);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    eu_pc = '0;
    m_c = 1'b0; m_n = 1'b0; m_z = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [15:0] ir);
    bus.mem_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.ir_out  = ir;
    eu_pc       = eu_pc + 16'd1;
    bus.mem_rdy = 1'($urandom);
    @(posedge clk);
    #1;
  endtask

  // One complete instruction: fw wait cycles in fetch, ew in LD/ST execute,
  // cnz < 0 means random ALU flags.
  task automatic run_instr(input logic [15:0] ir, input int fw, input int ew,
                           input int cnz);
    logic [3:0]  op;
    logic        taken;
    logic        rdy;
    logic [2:0]  f3;
    logic [15:0] pc_exp;
    logic [23:0] ev, em, ob;
    int          n_exec;
    op     = ir[15:12];
    taken  = (op == 4'h5) || (op == 4'h6 && m_z) || (op == 4'h7 && !m_z) ||
             (op == 4'h8 && m_n) || (op == 4'h9 && m_c);
    pc_exp = eu_pc + 16'd1;
    if (taken)      pc_exp = pc_exp + {{8{ir[7]}}, ir[7:0]};
    if (op == 4'hA) pc_exp = regs[ir[8:6]];

    for (int k = 0; k <= fw; k++) begin
      rdy         = (k == fw);
      bus.mem_rdy = rdy;
      set_flags(3'($urandom));
      @(negedge clk);
      ob = observe();
      ev = '0; em = M_STROBES;
      ev[B_MEMRD] = 1'b1; ev[B_IRLD] = rdy; ev[B_PCINC] = rdy; em[B_ADRSEL] = 1'b1;
      n_cmp++;
      if ((ob & em) !== ev) begin
        n_bad++;
        $display("FAIL fetch ir=%h cyc%0d: got %h want %h", ir, k, ob & em, ev);
      end
      clock_eu(ob, ir);
    end

    bus.mem_rdy = 1'($urandom);
    set_flags(3'($urandom));
    @(negedge clk);
    ob = observe();
    n_cmp++;
    if ((ob & M_ALLCTL) !== 24'h0) begin
      n_bad++;
      $display("FAIL decode ir=%h: got %h want 000000", ir, ob & M_ALLCTL);
    end
    clock_eu(ob, ir);

    n_exec = (op == 4'h3 || op == 4'h4) ? ew + 1 : 1;
    for (int k = 0; k < n_exec; k++) begin
      rdy         = (op == 4'h3 || op == 4'h4) ? (k == ew) : 1'($urandom);
      bus.mem_rdy = rdy;
      f3          = (cnz < 0) ? 3'($urandom) : 3'(cnz);
      set_flags(f3);
      if (op == 4'h1 || op == 4'h2) {m_c, m_n, m_z} = f3;
      @(negedge clk);
      ob = observe();
      ev = '0; em = M_STROBES;
      case (op)
        4'h1, 4'h2: begin
          ev[B_WEN] = 1'b1; em[B_SSEL] = 1'b1;
          ev[12:0] = {ir[11:9], ir[8:6], ir[5:3], op == 4'h2, ir[2:0]};
          em[12:0] = '1;
        end
        4'h3: begin
          ev[B_ADRSEL] = 1'b1; em[B_ADRSEL] = 1'b1;
          ev[B_SSEL] = 1'b1; em[B_SSEL] = 1'b1;
          ev[B_MEMRD] = 1'b1; ev[B_WEN] = rdy;
          ev[12:7] = {ir[11:9], ir[8:6]}; em[12:7] = '1;
          ev[3:0] = 4'h1; em[3:0] = '1;
        end
        4'h4: begin
          ev[B_ADRSEL] = 1'b1; em[B_ADRSEL] = 1'b1; ev[B_MEMWE] = 1'b1;
          ev[9:0] = {ir[8:6], ir[5:3], 4'h1}; em[9:0] = '1;
        end
        4'h5, 4'h6, 4'h7, 4'h8, 4'h9: begin
          em[B_PCSEL] = 1'b1; ev[B_PCLD] = taken;
        end
        4'hA: begin
          ev[B_PCSEL] = 1'b1; em[B_PCSEL] = 1'b1; ev[B_PCLD] = 1'b1;
          ev[9:7] = ir[8:6]; em[9:7] = '1; em[3:0] = '1;
        end
        default: ;
      endcase
      n_cmp++;
      if ((ob & em) !== ev) begin
        n_bad++;
        $display("FAIL exec ir=%h cyc%0d: got %h want %h", ir, k, ob & em, ev);
      end
      clock_eu(ob, ir);
    end

    n_cmp++;
    if (eu_pc !== pc_exp) begin
      n_bad++;
      $display("FAIL pc ir=%h: got %h want %h", ir, eu_pc, pc_exp);
    end
  endtask

  // Confirms the FSM is back in FETCH right after the previous instruction.
  task automatic expect_fetch(input string tag);
    logic [23:0] ob;
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    ob = observe();
    n_cmp++;
    if (ob[B_MEMRD] !== 1'b1 || ob[B_ADRSEL] !== 1'b0 || ob[B_IRLD] !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got mem_rd=%b adr_sel=%b ir_ld=%b want 1 0 0",
               tag, ob[B_MEMRD], ob[B_ADRSEL], ob[B_IRLD]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [23:0] ob;
    do_reset();
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    bus.mem_rdy = 1'b1;
    #1;
    ob = observe();
    n_cmp++;
    if (ob !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_async: got %h want 000000", ob);
    end
    repeat (2) begin
      @(negedge clk);
      ob = observe();
      n_cmp++;
      if (ob !== 24'h0) begin
        n_bad++;
        $display("FAIL reset_hold: got %h want 000000", ob);
      end
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    ob = observe();
    n_cmp++;
    if (ob !== 24'h0) begin
      n_bad++;
      $display("FAIL rst_cycle1: got %h want 000000", ob);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    ob = observe();
    n_cmp++;
    if (ob[B_IRLD] !== 1'b1 || ob[B_PCINC] !== 1'b1 || ob[B_MEMRD] !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_cycle2: got ir_ld=%b pc_inc=%b mem_rd=%b want 1 1 1",
               ob[B_IRLD], ob[B_PCINC], ob[B_MEMRD]);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_alu();
    do_reset();
    run_instr(16'h1A53, 0, 0, -1);
    expect_fetch("alu_3cyc");
  endtask

  task automatic test_ld();
    do_reset();
    run_instr(16'h3280, 0, 2, -1);
    expect_fetch("ld_wait");
    run_instr(16'h4A98, 1, 1, -1);
    expect_fetch("st_wait");
  endtask

  task automatic test_branch();
    do_reset();
    run_instr(16'h1000, 0, 0, 3'b001);
    run_instr(16'h60FE, 0, 0, -1);
    run_instr(16'h70FE, 0, 0, -1);
    run_instr(16'h3280, 0, 1, -1);
    run_instr(16'h6005, 0, 0, -1);
    run_instr(16'h2111, 0, 0, 3'b110);
    run_instr(16'h6005, 1, 0, -1);
    run_instr(16'h80F0, 0, 0, -1);
    run_instr(16'h9003, 0, 0, -1);
    run_instr(16'h5080, 0, 0, -1);
  endtask

  task automatic test_halt(input logic [15:0] ir, input logic ill);
    logic [23:0] ob, ev;
    do_reset();
    fetch_decode(ir);
    ev = '0; ev[B_HALTED] = 1'b1; ev[B_ILLEGAL] = ill;
    for (int k = 0; k < 5; k++) begin
      bus.mem_rdy = 1'($urandom);
      @(negedge clk);
      ob = observe();
      n_cmp++;
      if ((ob & M_ALLCTL) !== ev) begin
        n_bad++;
        $display("FAIL halt ir=%h cyc%0d: got %h want %h", ir, k, ob & M_ALLCTL, ev);
      end
      @(posedge clk);
      #1;
    end
    do_reset();
    @(negedge clk);
    ob = observe();
    n_cmp++;
    if (ob[B_HALTED] !== 1'b0 || ob[B_ILLEGAL] !== 1'b0 || ob[B_MEMRD] !== 1'b1) begin
      n_bad++;
      $display("FAIL halt_clear: got halted=%b illegal=%b mem_rd=%b want 0 0 1",
               ob[B_HALTED], ob[B_ILLEGAL], ob[B_MEMRD]);
    end
  endtask

  task automatic test_jr();
    do_reset();
    run_instr(16'hA0C0, 0, 0, -1);
    run_instr(16'hA1C0, 2, 0, -1);
    expect_fetch("jr_3cyc");
  endtask

  task automatic test_reset_mid_exec(input logic [15:0] ir);
    logic [23:0] ob;
    do_reset();
    fetch_decode(ir);
    bus.mem_rdy = 1'b0;
    @(negedge clk);
    ob = observe();
    n_cmp++;
    if ((ob[B_MEMRD] | ob[B_MEMWE]) !== 1'b1 || ob[B_WEN] !== 1'b0) begin
      n_bad++;
      $display("FAIL memop_wait ir=%h: got rd=%b we=%b w_en=%b", ir,
               ob[B_MEMRD], ob[B_MEMWE], ob[B_WEN]);
    end
    #2 reset = 1'b0;
    bus.mem_rdy = 1'b1;
    #1;
    ob = observe();
    n_cmp++;
    if (ob !== 24'h0) begin
      n_bad++;
      $display("FAIL reset_mid_exec ir=%h: got %h want 000000", ir, ob);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_random();
    logic [3:0] op;
    do_reset();
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 10));
      run_instr({op, 12'($urandom)}, int'($urandom_range(0, 2)),
                int'($urandom_range(0, 3)), -1);
    end
    expect_fetch("random_end");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset       = 1'b0;
    bus.ir_out  = '0;
    bus.mem_rdy = 1'b0;
    set_flags(3'b000);
    for (int i = 0; i < 8; i++) regs[i] = 16'($urandom);
    test_reset();
    test_alu();
    test_ld();
    test_branch();
    test_halt(16'hC000, 1'b1);
    test_halt(16'hF000, 1'b0);
    test_jr();
    test_reset_mid_exec(16'h3280);
    test_reset_mid_exec(16'h4A98);
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_cu.md
# cpu_cu

Control unit for the 16-bit RISC processor: a Moore/Mealy FSM driving every control input of the execution unit (register-file write/select, PC load/increment, IR load, address and PC-source muxes, ALU opcode and register addresses). It consumes the current instruction (`ir_out`) and status flags (`C`, `N`, `Z`) returned by the execution unit, and handshakes with instruction/data memory through `mem_rd`/`mem_we`/`mem_rdy`. `cpu_cu` plus the execution unit form the complete CPU core.

## Interface
- `RST_PC_HOLD`, 0: extra cycles held in `RST` state after reset release (0..3).
- `clk` in 1: system clock, all state on rising edge.
- `reset` in 1: asynchronous, active-low; forces `RST`, clears flags and all outputs.
- `ir_out` in 16: instruction register contents from the execution unit.
- `C`, `N`, `Z` in 1 each: ALU status from the execution unit.
- `mem_rdy` in 1: memory completes the current read/write this cycle.
- `w_en`, `s_sel`, `pc_ld`, `pc_inc`, `ir_ld`, `adr_sel`, `pc_sel` out 1 each: execution-unit controls.
- `W_Adr`, `R_Adr`, `S_Adr` out 3 each; `ALU_OP` out 4: datapath selects.
- `mem_rd`, `mem_we` out 1: memory strobes, held until `mem_rdy`.
- `halted` out 1: sticky, in `HALT`; `illegal` out 1: sticky, HALT caused by undefined opcode.

## Operation
- Format: op=ir[15:12], W=ir[11:9], R=ir[8:6], S=ir[5:3], f=ir[2:0], off=ir[7:0] (sign-extended by the EU).
- Opcodes: 0 NOP; 1 ALU with `ALU_OP`={0,f}; 2 ALU with `ALU_OP`={1,f}; 3 LD W←M[R]; 4 ST M[R]←S; 5 BR; 6 BEQ (Z); 7 BNE (!Z); 8 BMI (N); 9 BCS (C); A JR PC←R; F HALT; B–E illegal.
- States: `RST`→`FETCH`→`DECODE`→`EXEC`→`FETCH`; `HALT` terminal until reset.
- `FETCH`: `adr_sel`=0, `mem_rd`=1; on `mem_rdy` assert `ir_ld`=1 and `pc_inc`=1 in the same cycle, go to `DECODE`; otherwise stay.
- `DECODE`: all strobes 0; illegal op → `HALT` (`illegal`=1); HALT op → `HALT`; else `EXEC`.
- `EXEC` ALU: `R_Adr`=R, `S_Adr`=S, `W_Adr`=W, `s_sel`=0, `w_en`=1 one cycle; flags C/N/Z captured into internal flag register on that edge.
- `EXEC` LD: `adr_sel`=1, `R_Adr`=R, `mem_rd`=1, `s_sel`=1, `W_Adr`=W, `ALU_OP`=`ALU_PASS_S`; `w_en`=1 only in `mem_rdy` cycle; wait otherwise.
- `EXEC` ST: `adr_sel`=1, `R_Adr`=R, `S_Adr`=S, `ALU_OP`=`ALU_PASS_S`, `mem_we`=1 until `mem_rdy`.
- `EXEC` branch: `pc_sel`=0, `pc_ld`=1 iff condition true on captured flags (BR always); target = fetched PC + 1 + off.
- `EXEC` JR: `R_Adr`=R, `ALU_OP`=`ALU_PASS_R`, `pc_sel`=1, `pc_ld`=1.
- `pc_ld` and `pc_inc` never both 1; `mem_rd` and `mem_we` never both 1.

## Timing
- Reset (async): state=`RST`, flags=000, every output 0 (addresses and `ALU_OP` = 0), `halted`=`illegal`=0.
- After release: `RST` for 1+`RST_PC_HOLD` cycles, then `FETCH`.
- Zero-wait memory: NOP/ALU/branch/JR/LD/ST = 3 cycles each; each `mem_rdy`-low cycle adds one.
- Strobes are combinational from state, ir_out, flags, `mem_rdy`; `ir_out` stable from `DECODE` onward.
- Branches see flags from the most recent ALU instruction, not LD/ST.
- Reset asserted mid-`EXEC` LD/ST: strobes drop immediately, no register write.
- `mem_rdy` outside `FETCH`/LD/ST ignored.

## Structure
- Package `cpu_cu_pkg`: opcode constants, state encoding, `ALU_PASS_R`=4'h0, `ALU_PASS_S`=4'h1.
- Sub-module `cpu_cu_decode`: combinational ir_out → instruction class, fields, illegal flag.
- FSM, flag register, and output logic in `cpu_cu`.

## Test plan
- Reset low mid-FETCH, release with `mem_rdy`=1 → all outputs 0 during reset; `ir_ld`=`pc_inc`=1 on 2nd cycle after release.
- ir=16'h1A53 (ALU f=3, W=5,R=1,S=2), zero wait → `w_en`=1 with `ALU_OP`=4'h3, W=5,R=1,S=2, exactly 3 cycles.
- LD ir=16'h3280 with `mem_rdy` low 2 cycles → `mem_rd` held 3 EXEC cycles, `w_en`=1 only in last, `W_Adr`=1.
- ALU sets Z=1, then BEQ off=8'hFE → `pc_ld`=1, `pc_sel`=0; BNE same flags → `pc_ld`=0.
- ir=16'hC000 → `HALT` after DECODE, `halted`=`illegal`=1, no further `mem_rd` until reset.
- JR ir=16'hA0C0 → `R_Adr`=3, `ALU_OP`=4'h0, `pc_sel`=`pc_ld`=1, `pc_inc`=0.
